vending_controller: RTL and testbench

VENDING_CONTROLLER -- requirements
Module: vending_controller

---
 rtl/vend_pkg.sv | 23 ++
 rtl/credit_bcd.sv | 42 ++++
 rtl/vending_controller.sv | 215 +++++++++++++++++++++
 tb/tb_vending_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin values, CoinOut encoding and FSM state type for the vending controller.
package vend_pkg;

    localparam logic [4:0] NICKEL_VAL  = 5'd5;
    localparam logic [4:0] DIME_VAL    = 5'd10;
    localparam logic [4:0] QUARTER_VAL = 5'd25;

    localparam logic [1:0] COIN_NONE    = 2'd0;
    localparam logic [1:0] COIN_NICKEL  = 2'd1;
    localparam logic [1:0] COIN_DIME    = 2'd2;
    localparam logic [1:0] COIN_QUARTER = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } state_e;

    // Returned-coin counters stick at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/credit_bcd.sv
// Registered binary-to-BCD conversion of the credit value (three decimal digits).
module credit_bcd #(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CREDIT_W-1:0] bin,
    output logic [3:0]          bcd2,
    output logic [3:0]          bcd1,
    output logic [3:0]          bcd0
);

    logic [31:0] val_s;
    logic [3:0]  bcd2_d, bcd1_d, bcd0_d;
    logic [3:0]  bcd2_q, bcd1_q, bcd0_q;

    // Split the credit into hundreds, tens and units.
    always_comb begin
        val_s  = 32'(bin);
        bcd0_d = 4'(val_s % 32'd10);
        bcd1_d = 4'((val_s / 32'd10) % 32'd10);
        bcd2_d = 4'((val_s / 32'd100) % 32'd10);
    end

    // Digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd2_q <= 4'd0;
            bcd1_q <= 4'd0;
            bcd0_q <= 4'd0;
        end else begin
            bcd2_q <= bcd2_d;
            bcd1_q <= bcd1_d;
            bcd0_q <= bcd0_d;
        end
    end

    assign bcd2 = bcd2_q;
    assign bcd1 = bcd1_q;
    assign bcd0 = bcd0_q;

endmodule

// File: rtl/vending_controller.sv
// Coin-operated vending controller: credit accounting, item vend/deny and greedy change return.
// Optional feature macro VEND_AUTO_CHANGE_EN: return remaining credit automatically after a vend.
module vending_controller
    import vend_pkg::*;
#(
    parameter int                     NUM_ITEMS  = 4,
    parameter int                     CREDIT_W   = 8,
    parameter int                     MAX_CREDIT = 195,
    parameter logic [NUM_ITEMS*8-1:0] ITEM_PRICE = {8'd75, 8'd60, 8'd50, 8'd35}
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Quarter,
    input  logic                 Dime,
    input  logic                 Nickel,
    input  logic [NUM_ITEMS-1:0] Buy,
    input  logic                 Refund,
    output logic [NUM_ITEMS-1:0] Vending,
    output logic                 Deny,
    output logic                 CoinReject,
    output logic [1:0]           CoinOut,
    output logic                 ChangeDone,
    output logic [3:0]           QuarterCnt,
    output logic [3:0]           DimeCnt,
    output logic [3:0]           NickelCnt,
    output logic [CREDIT_W-1:0]  Credit,
    output logic [3:0]           Bcd2,
    output logic [3:0]           Bcd1,
    output logic [3:0]           Bcd0
);

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [NUM_ITEMS-1:0]  vend_q, vend_d;
    logic                  deny_q, deny_d;
    logic                  reject_q, reject_d;
    logic                  done_q, done_d;
    logic [1:0]            coin_out_q, coin_out_d;
    logic [3:0]            qcnt_q, qcnt_d, dcnt_q, dcnt_d, ncnt_q, ncnt_d;

    logic [NUM_ITEMS-1:0]  buy_low_s;
    logic [31:0]           credit_s, coin_val_s, price_s, step_val_s, sum_s;
    logic [1:0]            step_code_s, coin_num_s;
    logic                  coin_any_s, coin_fits_s, dispense_s, vend_ok_s;

    // Coin selection, lowest-bit item select and the greedy change step.
    always_comb begin
        credit_s    = 32'(credit_q);
        coin_any_s  = Quarter | Dime | Nickel;
        coin_num_s  = 2'(Quarter) + 2'(Dime) + 2'(Nickel);
        if (Quarter) begin
            coin_val_s = 32'(QUARTER_VAL);
        end else if (Dime) begin
            coin_val_s = 32'(DIME_VAL);
        end else if (Nickel) begin
            coin_val_s = 32'(NICKEL_VAL);
        end else begin
            coin_val_s = 32'd0;
        end
        // The fit check uses the credit before any same-cycle purchase.
        coin_fits_s = (credit_s + coin_val_s) <= 32'(MAX_CREDIT);
        buy_low_s   = Buy & (~Buy + NUM_ITEMS'(1));
        price_s     = 32'd0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (buy_low_s[i]) begin
                price_s = 32'(ITEM_PRICE[i*8 +: 8]);
            end else begin
                price_s = price_s;
            end
        end
        if (credit_s >= 32'(QUARTER_VAL)) begin
            step_val_s  = 32'(QUARTER_VAL);
            step_code_s = COIN_QUARTER;
        end else if (credit_s >= 32'(DIME_VAL)) begin
            step_val_s  = 32'(DIME_VAL);
            step_code_s = COIN_DIME;
        end else begin
            step_val_s  = 32'(NICKEL_VAL);
            step_code_s = COIN_NICKEL;
        end
    end

    // Next-state, next-credit and output-pulse computation.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        vend_d     = '0;
        deny_d     = 1'b0;
        reject_d   = 1'b0;
        done_d     = 1'b0;
        coin_out_d = COIN_NONE;
        qcnt_d     = qcnt_q;
        dcnt_d     = dcnt_q;
        ncnt_d     = ncnt_q;
        dispense_s = 1'b0;
        vend_ok_s  = 1'b0;
        sum_s      = credit_s;
        case (state_q)
            IDLE: begin
                if (Refund) begin
                    reject_d = coin_any_s;
                    qcnt_d   = 4'd0;
                    dcnt_d   = 4'd0;
                    ncnt_d   = 4'd0;
                    if (credit_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        dispense_s = 1'b1;
                        state_d    = CHANGE;
                    end
                end else begin
                    reject_d = (coin_num_s > 2'd1) || (coin_any_s && !coin_fits_s);
                    sum_s    = coin_fits_s ? credit_s + coin_val_s : credit_s;
                    if (buy_low_s != '0) begin
                        if (credit_s >= price_s) begin
                            vend_ok_s = 1'b1;
                            vend_d    = buy_low_s;
                            sum_s     = sum_s - price_s;
                        end else begin
                            deny_d = 1'b1;
                        end
                    end else begin
                        vend_d = '0;
                    end
                    credit_d = CREDIT_W'(sum_s);
`ifdef VEND_AUTO_CHANGE_EN
                    if (vend_ok_s && (sum_s != 32'd0)) begin
                        state_d = CHANGE;
                        qcnt_d  = 4'd0;
                        dcnt_d  = 4'd0;
                        ncnt_d  = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            CHANGE: begin
                reject_d = coin_any_s;
                if (credit_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    dispense_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (dispense_s) begin
            credit_d   = credit_q - CREDIT_W'(step_val_s);
            coin_out_d = step_code_s;
            case (step_code_s)
                COIN_QUARTER: qcnt_d = sat_inc4(qcnt_d);
                COIN_DIME:    dcnt_d = sat_inc4(dcnt_d);
                COIN_NICKEL:  ncnt_d = sat_inc4(ncnt_d);
                default:      coin_out_d = COIN_NONE;
            endcase
        end else begin
            coin_out_d = COIN_NONE;
        end
    end

    // FSM state and all registered outputs.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            vend_q     <= '0;
            deny_q     <= 1'b0;
            reject_q   <= 1'b0;
            done_q     <= 1'b0;
            coin_out_q <= COIN_NONE;
            qcnt_q     <= 4'd0;
            dcnt_q     <= 4'd0;
            ncnt_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            vend_q     <= vend_d;
            deny_q     <= deny_d;
            reject_q   <= reject_d;
            done_q     <= done_d;
            coin_out_q <= coin_out_d;
            qcnt_q     <= qcnt_d;
            dcnt_q     <= dcnt_d;
            ncnt_q     <= ncnt_d;
        end
    end

    credit_bcd #(
        .CREDIT_W (CREDIT_W)
    ) u_credit_bcd (
        .clk   (Clock),
        .rst_n (ResetN),
        .bin   (credit_q),
        .bcd2  (Bcd2),
        .bcd1  (Bcd1),
        .bcd0  (Bcd0)
    );

    assign Vending    = vend_q;
    assign Deny       = deny_q;
    assign CoinReject = reject_q;
    assign CoinOut    = coin_out_q;
    assign ChangeDone = done_q;
    assign QuarterCnt = qcnt_q;
    assign DimeCnt    = dcnt_q;
    assign NickelCnt  = ncnt_q;
    assign Credit     = credit_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed, table-driven bench for vending_controller (default parameters).
module tb_vending_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       quarter = 1'b0, dime = 1'b0, nickel = 1'b0, refund = 1'b0;
    logic [3:0] buy = 4'd0;
    logic [3:0] vending;
    logic       deny, coin_reject, change_done;
    logic [1:0] coin_out;
    logic [3:0] q_cnt, d_cnt, n_cnt, bcd2, bcd1, bcd0;
    logic [7:0] credit;

    int checks = 0;
    int errors = 0;

    vending_controller dut (
        .Clock      (clock),
        .ResetN     (reset_n),
        .Quarter    (quarter),
        .Dime       (dime),
        .Nickel     (nickel),
        .Buy        (buy),
        .Refund     (refund),
        .Vending    (vending),
        .Deny       (deny),
        .CoinReject (coin_reject),
        .CoinOut    (coin_out),
        .ChangeDone (change_done),
        .QuarterCnt (q_cnt),
        .DimeCnt    (d_cnt),
        .NickelCnt  (n_cnt),
        .Credit     (credit),
        .Bcd2       (bcd2),
        .Bcd1       (bcd1),
        .Bcd0       (bcd0)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       q, d, n;
        logic [3:0] buy;
        logic       refund;
        logic [3:0] vend;
        logic       deny, rej;
        logic [7:0] credit;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic q, input logic d, input logic n, input logic [3:0] b,
                                input logic r, input logic [3:0] v, input logic dn,
                                input logic rj, input logic [7:0] c);
        vec_t e;
        e.q = q; e.d = d; e.n = n; e.buy = b; e.refund = r;
        e.vend = v; e.deny = dn; e.rej = rj; e.credit = c;
        vt.push_back(e);
    endfunction

    // Apply one cycle of inputs, then sample just after the clock edge.
    task automatic step(input logic q, input logic d, input logic n, input logic [3:0] b, input logic r);
        @(negedge clock);
        quarter = q; dime = d; nickel = n; buy = b; refund = r;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_change(input string nm, input logic [1:0] co, input logic [7:0] c, input logic dn);
        chk({nm, " coin_out"}, 32'(coin_out), 32'(co));
        chk({nm, " credit"}, 32'(credit), 32'(c));
        chk({nm, " change_done"}, 32'(change_done), 32'(dn));
    endtask

    task automatic chk_counts(input string nm, input logic [3:0] qe, input logic [3:0] de, input logic [3:0] ne);
        chk({nm, " q_cnt"}, 32'(q_cnt), 32'(qe));
        chk({nm, " d_cnt"}, 32'(d_cnt), 32'(de));
        chk({nm, " n_cnt"}, 32'(n_cnt), 32'(ne));
    endtask

    initial begin
        int prev_credit;
        int exp_credit;
        logic [1:0] exp_code;
        logic [1:0] seq55 [3];
        logic [7:0] cred55 [3];
        bit fin;

        // Credit trail: 25,50,75, vend 35, deny, lowest-bit select, multi-coin rejects, overflow edge.
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd25);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd50);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd75);
        add(1'b0,1'b0,1'b0,4'b0001,1'b0, 4'b0001,1'b0,1'b0, 8'd40);
        add(1'b0,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd40);
        add(1'b0,1'b0,1'b0,4'b1000,1'b0, 4'b0000,1'b1,1'b0, 8'd40);
        add(1'b0,1'b1,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd50);
        add(1'b0,1'b0,1'b0,4'b0110,1'b0, 4'b0010,1'b0,1'b0, 8'd0);
        add(1'b1,1'b0,1'b1,4'b0000,1'b0, 4'b0000,1'b0,1'b1, 8'd25);
        add(1'b1,1'b1,1'b1,4'b0000,1'b0, 4'b0000,1'b0,1'b1, 8'd50);
        add(1'b0,1'b0,1'b1,4'b0001,1'b0, 4'b0001,1'b0,1'b0, 8'd20);
        add(1'b1,1'b0,1'b0,4'b0100,1'b0, 4'b0000,1'b1,1'b0, 8'd45);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd70);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd95);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd120);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd145);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd170);
        add(1'b0,1'b1,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd180);
        add(1'b0,1'b1,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd190);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b1, 8'd190);
        add(1'b0,1'b0,1'b1,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd195);
        add(1'b0,1'b0,1'b1,4'b0000,1'b0, 4'b0000,1'b0,1'b1, 8'd195);
        add(1'b0,1'b1,1'b1,4'b0000,1'b0, 4'b0000,1'b0,1'b1, 8'd195);
        add(1'b1,1'b0,1'b0,4'b0001,1'b0, 4'b0001,1'b0,1'b1, 8'd160);
        add(1'b1,1'b0,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd185);
        add(1'b0,1'b1,1'b0,4'b0000,1'b0, 4'b0000,1'b0,1'b0, 8'd195);

        // Reset state.
        #12;
        chk("reset credit", 32'(credit), 32'd0);
        chk("reset vending", 32'(vending), 32'd0);
        chk("reset coin_out", 32'(coin_out), 32'd0);
        chk("reset bcd", {20'd0, bcd2, bcd1, bcd0}, 32'd0);
        chk_counts("reset", 4'd0, 4'd0, 4'd0);
        @(negedge clock);
        reset_n = 1'b1;

        prev_credit = 0;
        foreach (vt[i]) begin
            step(vt[i].q, vt[i].d, vt[i].n, vt[i].buy, vt[i].refund);
            chk($sformatf("row%0d vending", i), 32'(vending), 32'(vt[i].vend));
            chk($sformatf("row%0d deny", i), 32'(deny), 32'(vt[i].deny));
            chk($sformatf("row%0d reject", i), 32'(coin_reject), 32'(vt[i].rej));
            chk($sformatf("row%0d credit", i), 32'(credit), 32'(vt[i].credit));
            chk($sformatf("row%0d coin_out", i), 32'(coin_out), 32'd0);
            chk($sformatf("row%0d bcd", i), 32'(bcd2) * 32'd100 + 32'(bcd1) * 32'd10 + 32'(bcd0),
                32'(prev_credit));
            prev_credit = int'(vt[i].credit);
        end

        // Refund at 195 beats a same-cycle buy and rejects the same-cycle coin.
        step(1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
        chk_change("refund195", 2'd3, 8'd170, 1'b0);
        chk("refund195 reject", 32'(coin_reject), 32'd1);
        chk("refund195 vending", 32'(vending), 32'd0);
        chk("refund195 deny", 32'(deny), 32'd0);
        chk_counts("refund195", 4'd1, 4'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'b0001, 1'b1);
        chk_change("change ignore", 2'd3, 8'd145, 1'b0);
        chk("change ignore reject", 32'(coin_reject), 32'd1);
        chk("change ignore vending", 32'(vending), 32'd0);
        exp_credit = 145;
        fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
            if (exp_credit == 0) begin
                chk_change("change end", 2'd0, 8'd0, 1'b1);
                fin = 1'b1;
            end else begin
                if (exp_credit >= 25) begin
                    exp_code = 2'd3; exp_credit -= 25;
                end else if (exp_credit >= 10) begin
                    exp_code = 2'd2; exp_credit -= 10;
                end else begin
                    exp_code = 2'd1; exp_credit -= 5;
                end
                chk_change($sformatf("change k%0d", k), exp_code, 8'(exp_credit), 1'b0);
            end
        end
        chk("change finished", 32'(fin), 32'd1);
        chk_counts("after195", 4'd7, 4'd2, 4'd0);

        // Counts hold across later IDLE activity.
        step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        chk_change("hold", 2'd0, 8'd5, 1'b0);
        chk_counts("hold", 4'd7, 4'd2, 4'd0);

        // Credit 55: quarter, quarter, nickel, then ChangeDone.
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("credit55", 32'(credit), 32'd55);
        seq55[0] = 2'd3; seq55[1] = 2'd3; seq55[2] = 2'd1;
        cred55[0] = 8'd30; cred55[1] = 8'd5; cred55[2] = 8'd0;
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk_change($sformatf("c55 k%0d", k), seq55[k], cred55[k], 1'b0);
            step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        end
        chk_change("c55 done", 2'd0, 8'd0, 1'b1);
        chk_counts("c55", 4'd2, 4'd0, 4'd1);

        // Refund with zero credit: ChangeDone right away, counts cleared.
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        chk_change("refund0", 2'd0, 8'd0, 1'b1);
        chk_counts("refund0", 4'd0, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("refund0 pulse", 32'(change_done), 32'd0);

        // Credit 10, buy the 75-cent item: deny, credit unchanged.
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
        chk("deny10 deny", 32'(deny), 32'd1);
        chk("deny10 credit", 32'(credit), 32'd10);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("deny10 pulse", 32'(deny), 32'd0);

        // Reset asserted during the second change cycle.
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        chk_change("rst c1", 2'd3, 8'd35, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk_change("rst c2", 2'd3, 8'd10, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_change("rst async", 2'd0, 8'd0, 1'b0);
        chk_counts("rst async", 4'd0, 4'd0, 4'd0);
        @(posedge clock);
        #1;
        chk_change("rst held", 2'd0, 8'd0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk_change("rst idle", 2'd0, 8'd25, 1'b0);
        chk("rst idle reject", 32'(coin_reject), 32'd0);

        // Vend leaving 25 cents: auto-change only with VEND_AUTO_CHANGE_EN.
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("auto credit100", 32'(credit), 32'd100);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
        chk("auto vending", 32'(vending), 32'd8);
        chk("auto credit", 32'(credit), 32'd25);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
`ifdef VEND_AUTO_CHANGE_EN
        chk_change("auto coin", 2'd3, 8'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk_change("auto done", 2'd0, 8'd0, 1'b1);
`else
        chk_change("retain", 2'd0, 8'd25, 1'b0);
        chk("retain bcd", {20'd0, bcd2, bcd1, bcd0}, 32'h0000_0025);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
